stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 158 +++++++++++++++
 tb/tb_stage_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage sequencer with stall, memory wait, decode-time skips, flush and retire count
// Moore FSM: every output is registered from the next-state decode, so inputs never reach outputs in the same cycle.
module stage_sequencer #(
  parameter int NUM_STAGES   = 5,
  parameter int WAIT_STAGE   = 3,
  parameter int DECODE_STAGE = 1,
  parameter int COUNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  mem_ready,
  input  logic [NUM_STAGES-1:0] skip_mask,
  input  logic                  flush,
  input  logic                  stop,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic [NUM_STAGES-1:0] latch_en,
  output logic                  commit,
  output logic                  busy,
  output logic [COUNT_W-1:0]    retire_count
);

  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("stage_sequencer: NUM_STAGES must be 2..8");
  end
  if (WAIT_STAGE < 0 || WAIT_STAGE > NUM_STAGES - 1) begin : g_bad_wait_stage
    $error("stage_sequencer: WAIT_STAGE must be 0..NUM_STAGES-1");
  end
  if (DECODE_STAGE < 0 || DECODE_STAGE > NUM_STAGES - 2) begin : g_bad_decode_stage
    $error("stage_sequencer: DECODE_STAGE must be 0..NUM_STAGES-2");
  end
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("stage_sequencer: COUNT_W must be at least 1");
  end

  localparam int IW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0] WAIT_IDX   = IW'(WAIT_STAGE);
  localparam logic [IW-1:0] DECODE_IDX = IW'(DECODE_STAGE);

  // Only stages strictly between decode and the final stage may be bypassed.
  function automatic logic [NUM_STAGES-1:0] skip_valid_mask();
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (k > DECODE_STAGE && k < NUM_STAGES - 1) m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NUM_STAGES-1:0] SKIP_VALID = skip_valid_mask();

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_LATCH
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_STAGES-1:0]   skip_q, skip_d;
  logic [COUNT_W-1:0]      retire_q, retire_d;
  logic [NUM_STAGES-1:0]   stage_onehot_q, stage_onehot_d;
  logic [NUM_STAGES-1:0]   latch_en_q, latch_en_d;
  logic                    commit_q, commit_d;
  logic                    busy_q, busy_d;
  logic [NUM_STAGES-1:0]   eff_skip;
  logic [IW-1:0]           next_idx;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    skip_d   = skip_q;
    retire_d = retire_q;

    // Leaving the decode latch uses the mask being captured this very cycle.
    eff_skip = (idx_q == DECODE_IDX) ? (skip_mask & SKIP_VALID) : skip_q;
    next_idx = LAST_IDX;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (j > int'(idx_q) && !eff_skip[j]) next_idx = IW'(j);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          idx_d   = '0;
        end
      end
      S_EXEC: begin
        if (flush) begin
          idx_d  = '0;
          skip_d = '0;
        end else if (!stall && (idx_q != WAIT_IDX || mem_ready)) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (idx_q == LAST_IDX) retire_d = retire_q + COUNT_W'(1);
        if (flush) begin
          state_d = S_EXEC;
          idx_d   = '0;
          skip_d  = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = stop ? S_IDLE : S_EXEC;
          idx_d   = '0;
          skip_d  = '0;
        end else begin
          if (idx_q == DECODE_IDX) skip_d = skip_mask & SKIP_VALID;
          state_d = S_EXEC;
          idx_d   = next_idx;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        skip_d  = '0;
      end
    endcase

    stage_onehot_d = '0;
    latch_en_d     = '0;
    if (state_d == S_EXEC)  stage_onehot_d[idx_d] = 1'b1;
    if (state_d == S_LATCH) latch_en_d[idx_d]     = 1'b1;
    commit_d = (state_d == S_LATCH) && (idx_d == LAST_IDX);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      skip_q         <= '0;
      retire_q       <= '0;
      stage_onehot_q <= '0;
      latch_en_q     <= '0;
      commit_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      skip_q         <= skip_d;
      retire_q       <= retire_d;
      stage_onehot_q <= stage_onehot_d;
      latch_en_q     <= latch_en_d;
      commit_q       <= commit_d;
      busy_q         <= busy_d;
    end
  end

  assign stage_onehot = stage_onehot_q;
  assign latch_en     = latch_en_q;
  assign commit       = commit_q;
  assign busy         = busy_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - self-checking bench for stage_sequencer with directed and random stimulus
module tb_stage_sequencer;
  localparam int N  = 5;
  localparam int WS = 3;
  localparam int DS = 1;

  logic         clk = 1'b0;
  logic         reset, start, stall, mem_ready, flush, stop;
  logic [N-1:0] skip_mask;
  logic [N-1:0] stage_onehot, latch_en;
  logic         commit, busy;
  logic [31:0]  retire_count;
  logic [N-1:0] so4, le4;
  logic         c4, b4;
  logic [3:0]   rc4;

  int n_assert = 0;
  int n_fail   = 0;

  bit           m_busy;
  bit           m_latch;
  int           m_stage;
  bit [N-1:0]   m_skip;
  longint       m_retired;
  bit           saw_le2;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(N), .WAIT_STAGE(WS), .DECODE_STAGE(DS), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .mem_ready(mem_ready),
    .skip_mask(skip_mask), .flush(flush), .stop(stop),
    .stage_onehot(stage_onehot), .latch_en(latch_en), .commit(commit), .busy(busy),
    .retire_count(retire_count)
  );

  stage_sequencer #(.NUM_STAGES(N), .WAIT_STAGE(WS), .DECODE_STAGE(DS), .COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .mem_ready(mem_ready),
    .skip_mask(skip_mask), .flush(flush), .stop(stop),
    .stage_onehot(so4), .latch_en(le4), .commit(c4), .busy(b4),
    .retire_count(rc4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural view: an instruction walks stages 0..N-1, each stage spends one or more
  // execute cycles then one latch cycle; stages marked in the decoded skip set are jumped over.
  task automatic model_clock();
    bit commit_now;
    commit_now = m_busy && m_latch && (m_stage == N - 1);
    if (reset) begin
      m_busy = 0; m_latch = 0; m_stage = 0; m_skip = '0; m_retired = 0;
      return;
    end
    if (commit_now) m_retired++;
    if (!m_busy) begin
      if (start) begin m_busy = 1; m_latch = 0; m_stage = 0; end
    end else if (flush) begin
      m_latch = 0; m_stage = 0; m_skip = '0;
    end else if (!m_latch) begin
      if (!stall && (m_stage != WS || mem_ready)) m_latch = 1;
    end else begin
      if (m_stage == DS) begin
        for (int k = DS + 1; k < N - 1; k++) m_skip[k] = skip_mask[k];
      end
      m_latch = 0;
      if (m_stage == N - 1) begin
        m_skip = '0; m_stage = 0;
        if (stop) m_busy = 0;
      end else begin
        m_stage++;
        while (m_skip[m_stage]) m_stage++;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] e_so, e_le;
    @(posedge clk);
    model_clock();
    #1;
    e_so = '0;
    e_le = '0;
    if (m_busy && !m_latch) e_so[m_stage] = 1'b1;
    if (m_busy && m_latch)  e_le[m_stage] = 1'b1;
    check("stage_onehot", stage_onehot, e_so);
    check("latch_en", latch_en, e_le);
    check("commit", commit, m_busy && m_latch && m_stage == N - 1);
    check("busy", busy, m_busy);
    check("retire_count", retire_count, m_retired[31:0]);
    check("retire_count_w4", rc4, m_retired % 16);
    check("w4_outputs", {so4, le4, c4, b4}, {e_so, e_le, m_busy && m_latch && m_stage == N - 1, m_busy});
    if (latch_en[2]) saw_le2 = 1'b1;
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; stall = 0; mem_ready = 1; flush = 0; stop = 0; skip_mask = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_busy = 0; m_latch = 0; m_stage = 0; m_skip = '0; m_retired = 0; saw_le2 = 0;

    step(); step();
    check("reset_all_zero", {stage_onehot, latch_en, commit, busy, retire_count}, '0);

    reset = 0;
    flush = 1;
    step(); step();
    check("no_autostart_flush_idle", busy, 1'b0);
    flush = 0;

    // Basic timing: start in cycle 0.
    start = 1; step(); start = 0;
    check("c1_exec0", stage_onehot, 5'b00001);
    step();
    check("c2_latch0", latch_en, 5'b00001);
    repeat (8) step();
    check("c10_latch4", latch_en, 5'b10000);
    check("c10_commit", commit, 1'b1);
    step();
    check("c11_retire", retire_count, 32'd1);
    check("c11_exec0", stage_onehot, 5'b00001);

    // Memory wait: EXEC(3) entered at cycle 17.
    repeat (6) step();
    check("wait_exec3_entry", stage_onehot, 5'b01000);
    mem_ready = 0;
    repeat (3) begin
      step();
      check("wait_hold_exec3", stage_onehot, 5'b01000);
      check("wait_no_latch3", latch_en[3], 1'b0);
    end
    mem_ready = 1;
    step(); step(); step();
    check("wait_commit_late", commit, 1'b1);
    step();
    check("wait_retire", retire_count, 32'd2);

    // Skip mask presented in LATCH(1).
    saw_le2 = 0;
    repeat (3) step();
    check("skip_at_latch1", latch_en, 5'b00010);
    skip_mask = 5'b10101;
    step();
    skip_mask = '0;
    check("skip_goes_exec3", stage_onehot, 5'b01000);
    repeat (3) step();
    check("skip_commit_c8", commit, 1'b1);
    check("skip_no_latch2", saw_le2, 1'b0);

    // Skip register cleared: stage 2 executes in the next instruction.
    repeat (5) step();
    check("skip_cleared_exec2", stage_onehot, 5'b00100);

    // Flush in EXEC(3).
    step(); step();
    check("flush_at_exec3", stage_onehot, 5'b01000);
    flush = 1; step(); flush = 0;
    check("flush_restart", stage_onehot, 5'b00001);
    check("flush_no_commit", commit, 1'b0);
    check("flush_retire_kept", retire_count, 32'd3);

    // Stop in the commit cycle.
    repeat (9) step();
    check("stop_at_commit", commit, 1'b1);
    stop = 1; step(); stop = 0;
    check("stop_idle", busy, 1'b0);
    flush = 1; step(); flush = 0;
    check("flush_in_idle", {busy, stage_onehot}, '0);

    // Reset during EXEC(2).
    start = 1; step(); start = 0;
    repeat (4) step();
    check("rst_at_exec2", stage_onehot, 5'b00100);
    reset = 1; step(); reset = 0;
    check("rst_mid_outputs", {stage_onehot, latch_en, commit, busy, retire_count}, '0);

    // Narrow counter wrap.
    start = 1; step(); start = 0;
    repeat (150) step();
    check("w4_at_15", rc4, 4'd15);
    repeat (10) step();
    check("w4_wrap_0", rc4, 4'd0);
    check("w32_at_16", retire_count, 32'd16);

    // Random run against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 1) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 1) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 7) == 0);
      skip_mask = N'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
